// File: rtl/alu_operand_collector.sv
// Operand collector in front of the 8-bit ALU: merges command/operand beats into one
// ALU input bus with a ce pulse, stretched for arithmetic multiply, with a missing-operand timeout.
module alu_operand_collector #(
  parameter int OPWIDTH  = 8,
  parameter int CMDWIDTH = 4,
  parameter int TIMEOUT  = 16,
  parameter int MUL_HOLD = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CMDWIDTH-1:0] s_cmd,
  input  logic                s_m,
  input  logic                s_cin,
  input  logic [OPWIDTH-1:0]  s_opa,
  input  logic                s_opa_vld,
  input  logic [OPWIDTH-1:0]  s_opb,
  input  logic                s_opb_vld,
  output logic [OPWIDTH-1:0]  opa,
  output logic [OPWIDTH-1:0]  opb,
  output logic [CMDWIDTH-1:0] cmd,
  output logic                m,
  output logic                cin,
  output logic [1:0]          inp_valid,
  output logic                ce,
  output logic                busy,
  output logic                timeout
);

  localparam int CW = $clog2(TIMEOUT);
  localparam int HW = $clog2(MUL_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                state_r;
  logic [CMDWIDTH-1:0]   cmd_r;
  logic                  m_r;
  logic                  cin_r;
  logic [OPWIDTH-1:0]    opa_h_r;
  logic [OPWIDTH-1:0]    opb_h_r;
  logic [1:0]            got_r;
  logic [CW-1:0]         cnt_r;
  logic [HW-1:0]         hold_r;

  logic                  accept_s;
  logic [1:0]            vld_in_s;
  logic [1:0]            req_s;
  logic [1:0]            got_s;
  logic [1:0]            iv_s;
  logic [OPWIDTH-1:0]    opa_s;
  logic [OPWIDTH-1:0]    opb_s;
  logic [CMDWIDTH-1:0]   cmd_s;
  logic                  m_s;
  logic                  cin_s;
  logic                  done_s;
  logic                  expire_s;
  logic                  issue_s;

  // Required operand mask {needB, needA} for a given mode and command.
  function automatic logic [1:0] req_mask(input logic mode, input logic [CMDWIDTH-1:0] c);
    logic [1:0] r;
    if (mode) begin
      case (c)
        CMDWIDTH'(0), CMDWIDTH'(1), CMDWIDTH'(2), CMDWIDTH'(3),
        CMDWIDTH'(8), CMDWIDTH'(9), CMDWIDTH'(10), CMDWIDTH'(11),
        CMDWIDTH'(12):                r = 2'b11;
        CMDWIDTH'(4), CMDWIDTH'(5):   r = 2'b01;
        CMDWIDTH'(6), CMDWIDTH'(7):   r = 2'b10;
        default:                      r = 2'b00;
      endcase
    end else begin
      case (c)
        CMDWIDTH'(0), CMDWIDTH'(1), CMDWIDTH'(2), CMDWIDTH'(3),
        CMDWIDTH'(4), CMDWIDTH'(5):   r = 2'b11;
        CMDWIDTH'(6), CMDWIDTH'(8), CMDWIDTH'(9), CMDWIDTH'(12),
        CMDWIDTH'(13):                r = 2'b01;
        CMDWIDTH'(7), CMDWIDTH'(10),
        CMDWIDTH'(11):                r = 2'b10;
        default:                      r = 2'b00;
      endcase
    end
    return r;
  endfunction

  assign s_ready = ~rst & ((state_r == IDLE) | (state_r == COLLECT));

  // Merge the incoming beat with held state; in IDLE the beat itself supplies cmd/m/cin.
  always_comb begin
    accept_s = s_valid & s_ready;
    vld_in_s = {s_opb_vld, s_opa_vld} & {2{accept_s}};
    if (state_r == IDLE) begin
      cmd_s = s_cmd;
      m_s   = s_m;
      cin_s = s_cin;
      got_s = vld_in_s;
      opa_s = vld_in_s[0] ? s_opa : {OPWIDTH{1'b0}};
      opb_s = vld_in_s[1] ? s_opb : {OPWIDTH{1'b0}};
    end else begin
      cmd_s = cmd_r;
      m_s   = m_r;
      cin_s = cin_r;
      got_s = got_r | vld_in_s;
      opa_s = vld_in_s[0] ? s_opa : opa_h_r;
      opb_s = vld_in_s[1] ? s_opb : opb_h_r;
    end
    req_s    = req_mask(m_s, cmd_s);
    done_s   = ((got_s & req_s) == req_s);
    expire_s = (state_r == COLLECT) && !done_s && (cnt_r == CW'(TIMEOUT - 1));
    issue_s  = ((state_r == IDLE) && accept_s && done_s) ||
               ((state_r == COLLECT) && (done_s || expire_s));
    iv_s     = expire_s ? got_s : (got_s & req_s);
  end

  // Collector FSM with registered ALU bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cmd_r     <= {CMDWIDTH{1'b0}};
      m_r       <= 1'b0;
      cin_r     <= 1'b0;
      opa_h_r   <= {OPWIDTH{1'b0}};
      opb_h_r   <= {OPWIDTH{1'b0}};
      got_r     <= 2'b00;
      cnt_r     <= {CW{1'b0}};
      hold_r    <= {HW{1'b0}};
      opa       <= {OPWIDTH{1'b0}};
      opb       <= {OPWIDTH{1'b0}};
      cmd       <= {CMDWIDTH{1'b0}};
      m         <= 1'b0;
      cin       <= 1'b0;
      inp_valid <= 2'b00;
      ce        <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (issue_s) begin
        opa       <= iv_s[0] ? opa_s : {OPWIDTH{1'b0}};
        opb       <= iv_s[1] ? opb_s : {OPWIDTH{1'b0}};
        cmd       <= cmd_s;
        m         <= m_s;
        cin       <= cin_s;
        inp_valid <= iv_s;
        ce        <= 1'b1;
        timeout   <= expire_s;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cmd_r   <= s_cmd;
            m_r     <= s_m;
            cin_r   <= s_cin;
            opa_h_r <= opa_s;
            opb_h_r <= opb_s;
            got_r   <= got_s;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= done_s ? ISSUE : COLLECT;
          end else begin
            busy    <= 1'b0;
          end
        end
        COLLECT: begin
          opa_h_r <= opa_s;
          opb_h_r <= opb_s;
          got_r   <= got_s;
          if (issue_s) begin
            state_r <= ISSUE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        ISSUE: begin
          timeout <= 1'b0;
          if (m_r && (cmd_r == CMDWIDTH'(9)) && (MUL_HOLD > 1)) begin
            hold_r  <= HW'(1);
            state_r <= HOLD;
          end else begin
            ce        <= 1'b0;
            inp_valid <= 2'b00;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        HOLD: begin
          if (hold_r == HW'(MUL_HOLD - 1)) begin
            ce        <= 1'b0;
            inp_valid <= 2'b00;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            hold_r    <= hold_r + HW'(1);
          end
        end
        default: begin
          ce        <= 1'b0;
          inp_valid <= 2'b00;
          timeout   <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Upstream stage of the 8-bit ALU. Accepts command and operand beats from the instruction source, where opa and opb may arrive in different cycles.
- Merges the beats and drives the ALU input bus (opa, opb, cmd, m, cin, inp_valid, ce) with a one-cycle ce pulse.
- Holds the bus stable for the multi-cycle arithmetic multiply (m=1, cmd=9).
- Bounds waiting for a missing operand with a timeout; on expiry it issues with a partial inp_valid so the ALU raises err.

Parameters:
OPWIDTH, 8, operand width
CMDWIDTH, 4, command width
TIMEOUT, 16, max cycles spent in COLLECT waiting for missing operands (>=2)
MUL_HOLD, 3, cycles ce/bus held for arithmetic cmd 9 (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  collector can accept a beat
s_cmd  in  CMDWIDTH  command (sampled on first beat only)
s_m  in  1  mode, 1=arithmetic (first beat only)
s_cin  in  1  carry in (first beat only)
s_opa  in  OPWIDTH  operand A
s_opa_vld  in  1  s_opa valid in this beat
s_opb  in  OPWIDTH  operand B
s_opb_vld  in  1  s_opb valid in this beat
opa  out  OPWIDTH  to ALU
opb  out  OPWIDTH  to ALU
cmd  out  CMDWIDTH  to ALU
m  out  1  to ALU
cin  out  1  to ALU
inp_valid  out  2  to ALU, {opb_got, opa_got}
ce  out  1  ALU clock enable
busy  out  1  state != IDLE
timeout  out  1  one-cycle pulse concurrent with a timed-out issue

Behaviour:
- Reset:
  - Synchronous; state=IDLE; all outputs 0; got mask=00; counter=0.
  - s_ready=0 while rst high.
  - Reset mid-COLLECT or mid-HOLD aborts the operation; no ce afterwards.
- Required mask req={needB,needA} from (m,cmd):
  - m=1: cmd 0-3, 8-12 -> 11; cmd 4,5 -> 01; cmd 6,7 -> 10; cmd 13-15 -> 00.
  - m=0: cmd 0-5 -> 11; cmd 6,8,9,12,13 -> 01; cmd 7,10,11 -> 10; cmd 14,15 -> 00.
- Handshake:
  - Beat accepted when s_valid & s_ready.
  - s_ready=1 in IDLE and COLLECT, 0 in ISSUE and HOLD.
- IDLE:
  - On accepted beat: capture cmd, m, cin; capture opa if s_opa_vld, opb if s_opb_vld; got={s_opb_vld,s_opa_vld}.
  - If (got & req)==req go to ISSUE, else go to COLLECT with counter=0.
  - req=00 issues immediately.
- COLLECT:
  - Accepted beats merge operands only; s_cmd, s_m, s_cin are ignored.
  - An operand already held is overwritten by a later valid beat (last wins).
  - If the merged got covers req, go to ISSUE.
  - Else if counter==TIMEOUT-1, go to ISSUE with timeout flagged.
  - Else counter+1.
  - Completion in the same cycle as expiry: completion wins, no timeout.
- Output registers:
  - Loaded on the transition into ISSUE.
  - inp_valid = got & req on normal issue, and raw got on timeout.
  - Operands not held are driven 0.
- ISSUE (1 cycle):
  - ce=1; timeout=1 if flagged.
  - If m=1 and cmd=9, go to HOLD with hold counter=1; else go to IDLE.
- HOLD:
  - ce=1; all bus outputs unchanged.
  - Leave to IDLE when the hold counter reaches MUL_HOLD-1, so ce is high for exactly MUL_HOLD cycles total.
  - MUL_HOLD=1 means no HOLD cycles.
- Outside ISSUE/HOLD:
  - ce=0, inp_valid=00, timeout=0.
  - opa, opb, cmd, m, cin retain the last issued values.
- Latency:
  - Completing beat at edge T gives ce high in cycle T+1.
  - Next beat is accepted in the cycle after the last ce cycle.
  - Throughput is 1 op per 2 cycles for single-cycle commands.
- No input buffering; beats presented while s_ready=0 are not consumed (source holds them).

Test Plan:
- m=0,cmd=0, single beat opa=0x3C, opb=0x0F, both vld -> next cycle ce=1 for 1 cycle, inp_valid=11, opa=3C, opb=0F, cmd=0; s_ready=0 that cycle, then 1.
- m=1,cmd=0: beat1 opa=0x10 only, 3 idle cycles, beat2 opb=0x20 only -> ce 1 cycle after beat2, inp_valid=11, opa=10, opb=20, timeout=0.
- m=1,cmd=4, beat with opa=0x7F plus opb_vld=1 opb=0x55 -> inp_valid=01, opb=00, opa=7F, single ce.
- m=0,cmd=4, opa only, no further beats -> exactly 16 cycles in COLLECT, then ce=1 with timeout=1, inp_valid=01; busy falls the cycle after.
- m=1,cmd=9, opa=3, opb=4 -> ce high 3 consecutive cycles with bus constant; s_ready=0 throughout; a beat held on s_valid is accepted in the cycle after ce falls.
- rst asserted during COLLECT (opa=0xAA held) -> next cycle all outputs 0, no ce; a new opb-only cmd=7,m=0 beat then issues inp_valid=10 with opa=00.
